// File: rtl/mult_operand_dispatcher_pkg.sv
// Shared types for the multiplier operand dispatcher: FSM state encoding
// and default operand/product widths.
package mult_operand_dispatcher_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_BUSY  = 2'd2,
      ST_DRAIN = 2'd3
   } disp_state_t;

   localparam int L_WORD_DEF = 4;
   localparam int PROD_W_DEF = 2 * L_WORD_DEF;

endpackage

// File: rtl/mult_operand_dispatcher_fifo.sv
// Operand-pair FIFO: DEPTH entries, wrap-bit pointers, registered full/empty
// flags so the producer-facing ready is a flop output.
module mult_op_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr_r, rd_ptr_r;
   logic [AW:0]      wr_ptr_nx_s, rd_ptr_nx_s;
   logic             do_push_s, do_pop_s;
   logic             full_r, empty_r;
   logic [WIDTH-1:0] mem_r [DEPTH];

   // Next-pointer computation; push/pop are ignored when they would over/underflow
   always_comb begin
      do_push_s = push && !full_r;
      do_pop_s  = pop && !empty_r;
      if (do_push_s) begin
         wr_ptr_nx_s = wr_ptr_r + {{AW{1'b0}}, 1'b1};
      end else begin
         wr_ptr_nx_s = wr_ptr_r;
      end
      if (do_pop_s) begin
         rd_ptr_nx_s = rd_ptr_r + {{AW{1'b0}}, 1'b1};
      end else begin
         rd_ptr_nx_s = rd_ptr_r;
      end
   end

   // Pointer, flag and storage update
   always_ff @(posedge clock) begin
      if (!reset) begin
         wr_ptr_r <= {(AW + 1){1'b0}};
         rd_ptr_r <= {(AW + 1){1'b0}};
         full_r   <= 1'b0;
         empty_r  <= 1'b1;
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {WIDTH{1'b0}};
         end
      end else begin
         wr_ptr_r <= wr_ptr_nx_s;
         rd_ptr_r <= rd_ptr_nx_s;
         empty_r  <= (wr_ptr_nx_s == rd_ptr_nx_s);
         full_r   <= (wr_ptr_nx_s[AW] != rd_ptr_nx_s[AW]) &&
                     (wr_ptr_nx_s[AW-1:0] == rd_ptr_nx_s[AW-1:0]);
         if (do_push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wdata;
         end
      end
   end

   assign rdata = mem_r[rd_ptr_r[AW-1:0]];
   assign full  = full_r;
   assign empty = empty_r;

endmodule

// File: rtl/mult_operand_dispatcher.sv
// Issue stage for the shift-add multiplier: FIFO-buffered operands, Start/Ready/Done
// tracking and a valid/ready result register. Optional watchdog: MULT_DISP_WDOG_EN.
module mult_operand_dispatcher
   import mult_operand_dispatcher_pkg::*;
#(
   parameter int L_word  = L_WORD_DEF,
   parameter int DEPTH   = 4,
   parameter int TMO_CYC = 4 * L_word + 8
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [L_word-1:0]     in_word1,
   input  logic [L_word-1:0]     in_word2,
   output logic [L_word-1:0]     word1,
   output logic [L_word-1:0]     word2,
   output logic                  Start,
   input  logic                  Ready,
   input  logic                  Done,
   input  logic [2*L_word-1:0]   product,
   output logic                  res_valid,
   input  logic                  res_ready,
   output logic [2*L_word-1:0]   res_product,
   output logic                  err
);

   localparam int PW = 2 * L_word;

   disp_state_t          state_r;
   logic [L_word-1:0]    word1_r, word2_r;
   logic                 res_valid_r;
   logic [PW-1:0]        res_product_r;
   logic [PW-1:0]        fifo_head_s;
   logic                 fifo_full_s, fifo_empty_s;
   logic                 push_s, pop_s;
   logic                 complete_s;
   logic                 timeout_s;

   assign push_s     = in_valid && !fifo_full_s;
   assign pop_s      = (state_r == ST_IDLE) && !fifo_empty_s && (!res_valid_r || res_ready);
   assign complete_s = (state_r == ST_BUSY) && Ready && Done;

   mult_op_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (PW)
   ) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (push_s),
      .pop   (pop_s),
      .wdata ({in_word1, in_word2}),
      .rdata (fifo_head_s),
      .full  (fifo_full_s),
      .empty (fifo_empty_s)
   );

`ifdef MULT_DISP_WDOG_EN
   localparam int WDW = $clog2(TMO_CYC + 1);
   localparam logic [WDW-1:0] WDOG_LIM = WDW'(TMO_CYC - 1);

   logic [WDW-1:0] wdog_r;
   logic           err_r;

   // Timeout fires on the TMO_CYC-th cycle spent in ISSUE/BUSY unless the result lands then
   always_comb begin
      if (((state_r == ST_ISSUE) || (state_r == ST_BUSY)) && (wdog_r == WDOG_LIM) && !complete_s) begin
         timeout_s = 1'b1;
      end else begin
         timeout_s = 1'b0;
      end
   end

   // Watchdog counter and sticky error flag
   always_ff @(posedge clock) begin
      if (!reset) begin
         wdog_r <= {WDW{1'b0}};
         err_r  <= 1'b0;
      end else begin
         if ((state_r == ST_ISSUE) || (state_r == ST_BUSY)) begin
            wdog_r <= wdog_r + {{(WDW - 1){1'b0}}, 1'b1};
         end else begin
            wdog_r <= {WDW{1'b0}};
         end
         if (timeout_s) begin
            err_r <= 1'b1;
         end
      end
   end

   assign err = err_r;
`else
   assign timeout_s = 1'b0;
   assign err       = 1'b0;
`endif

   // Issue FSM with operand holding and result registers
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_r       <= ST_IDLE;
         word1_r       <= {L_word{1'b0}};
         word2_r       <= {L_word{1'b0}};
         res_valid_r   <= 1'b0;
         res_product_r <= {PW{1'b0}};
      end else begin
         if (res_valid_r && res_ready) begin
            res_valid_r <= 1'b0;
         end
         case (state_r)
            ST_IDLE: begin
               if (pop_s) begin
                  {word1_r, word2_r} <= fifo_head_s;
                  state_r            <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (!Ready) begin
                  state_r <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (complete_s) begin
                  res_product_r <= product;
                  res_valid_r   <= 1'b1;
                  state_r       <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               state_r <= ST_IDLE;
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
         // Watchdog abort overrides the normal ISSUE/BUSY progression
         if (timeout_s) begin
            res_product_r <= {PW{1'b1}};
            res_valid_r   <= 1'b1;
            state_r       <= ST_DRAIN;
         end
      end
   end

   assign in_ready    = !fifo_full_s;
   assign Start       = (state_r == ST_ISSUE);
   assign word1       = word1_r;
   assign word2       = word2_r;
   assign res_valid   = res_valid_r;
   assign res_product = res_product_r;

endmodule
